delay_tap_reader: RTL



---
 rtl/delay_tap_reader.sv | 135 +++++++++++++
 1 files changed

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: circular-RAM delay line, runtime tap, 2 cycles ivalid->ovalid, 2-entry valid/ready output buffer.
// A full buffer with no pop drops the returning word; `DELAY_TAP_OVERRUN_EN adds a sticky overrun flag and drop counter.

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count;
  logic             push, pop;

  // A full buffer still accepts when the head leaves in the same cycle.
  assign out_vld = (count != '0);
  assign in_rdy  = (count != FULL) || out_rdy;
  assign push    = in_vld && in_rdy;
  assign pop     = out_vld && out_rdy;
  assign out_dat = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module delay_tap_reader #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ivalid,
  input  logic [WIDTH-1:0]      idata,
  input  logic                  tap_load,
  input  logic [ADDR_WIDTH-1:0] tap_in,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [WIDTH-1:0]      odata,
  output logic [ADDR_WIDTH-1:0] fill,
  output logic                  overrun
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] FILL_MAX = ADDR_WIDTH'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] TAP_MIN  = ADDR_WIDTH'(1);

  logic [WIDTH-1:0]      ram [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, tap, rd_addr;
  logic [WIDTH-1:0]      rd_dat;
  logic                  rd_issue, rd_vld, rd_rdy, drop;

  // fill gating keeps stale RAM unreachable after reset; tap >= 1 keeps rd_addr off wr_ptr.
  assign rd_issue = ivalid && (fill >= tap);
  assign rd_addr  = wr_ptr - tap;

  always_ff @(posedge clock) begin
    if (ivalid)   ram[wr_ptr] <= idata;
    if (rd_issue) rd_dat      <= ram[rd_addr];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      fill   <= '0;
      tap    <= TAP_MIN;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= rd_issue;
      if (ivalid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
      end
      if (tap_load) tap <= (tap_in == '0) ? TAP_MIN : tap_in;
    end
  end

  fifo #(.WIDTH(WIDTH), .DEPTH(2)) u_obuf (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (rd_vld),
    .in_rdy  (rd_rdy),
    .in_dat  (rd_dat),
    .out_vld (ovalid),
    .out_rdy (oready),
    .out_dat (odata)
  );

  assign drop = rd_vld && !rd_rdy;

`ifdef DELAY_TAP_OVERRUN_EN
  logic [15:0] drop_cnt;

  // A drop in the same cycle as tap_load wins, so no drop event is ever lost.
  always_ff @(posedge clock) begin
    if (!reset) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop)          overrun <= 1'b1;
      else if (tap_load) overrun <= 1'b0;
      if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
  assign overrun     = 1'b0;
`endif
endmodule
